mem_access_stage: RTL and testbench

Memory-stage consumer of the EX/MEM pipeline register in the multi-cycle core. It takes the registered ALU result, destination register and write/load/store flags, and performs the data-memory access through a request/ready handshake. It stalls upstream while the access is outstanding, then delivers a one-cycle MEM/WB writeback beat. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_access_stage.sv | 164 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage behind the EX/MEM pipeline register. ALU-only instructions
//   pass straight through to the MEM/WB beat with one cycle of latency.
//   Loads and stores are latched, issued to data memory with a req/ready
//   handshake, and the upstream pipe is stalled until the access completes.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     When defined, an ACCESS that sees TIMEOUT_CYCLES cycles without
//     mem_ready is aborted. The instruction is squashed (wb_valid=1,
//     wb_write=0) and mem_error pulses. When undefined, ACCESS waits forever
//     and mem_error is tied low.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   valid_in, is_*_in   EX/MEM control, sampled only while IDLE
//   alu_result_in       ALU result / memory address
//   register_d_in       destination register
//   store_data_in       store write data
//   stall_out           hold EX/MEM and earlier stages (high in ACCESS)
//   mem_req/we/addr/wdata, mem_ready, mem_rdata   data-memory handshake
//   wb_valid, wb_write, wb_data, wb_register_d    MEM/WB writeback beat
//   mem_error           timeout abort pulse
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        is_write_in,
    input  logic        is_load_in,
    input  logic        is_store_in,
    input  logic [31:0] alu_result_in,
    input  logic [4:0]  register_d_in,
    input  logic [31:0] store_data_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_write,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_register_d,
    output logic        mem_error
);

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t     state, state_nxt;
    logic       is_mem, accept_mem, done_ok, done_abort, timeout_hit;
    logic       lat_write;
    logic [4:0] lat_rd;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    // Abort on the edge where this non-ready cycle would bring the count
    // to TIMEOUT_CYCLES; a ready on that same edge wins (checked first).
    assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= done_abort;
            if (accept_mem)
                to_cnt <= '0;
            else if (state == ACCESS && !mem_ready)
                to_cnt <= to_cnt + CNT_W'(1);
        end
    end

    assign mem_error = err_q;
`else
    assign timeout_hit = 1'b0;
    assign mem_error   = 1'b0;
`endif

    assign stall_out = (state == ACCESS);

    always_comb begin
        state_nxt  = state;
        accept_mem = 1'b0;
        done_ok    = 1'b0;
        done_abort = 1'b0;
        is_mem     = is_load_in | is_store_in;
        case (state)
            IDLE: begin
                if (valid_in && is_mem) begin
                    accept_mem = 1'b1;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    done_abort = 1'b1;
                    state_nxt  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            wb_valid      <= 1'b0;
            wb_write      <= 1'b0;
            wb_data       <= '0;
            wb_register_d <= '0;
            lat_write     <= 1'b0;
            lat_rd        <= '0;
        end else begin
            state    <= state_nxt;
            wb_valid <= 1'b0;
            wb_write <= 1'b0;
            if (accept_mem) begin
                // Store wins when both flags are set; mem_we doubles as the
                // latched "is store" bit and mem_addr as the latched address.
                mem_req   <= 1'b1;
                mem_we    <= is_store_in;
                mem_addr  <= alu_result_in;
                mem_wdata <= store_data_in;
                lat_write <= is_write_in;
                lat_rd    <= register_d_in;
            end else if (state == IDLE && valid_in) begin
                wb_valid      <= 1'b1;
                wb_write      <= is_write_in;
                wb_data       <= alu_result_in;
                wb_register_d <= register_d_in;
            end else if (done_ok) begin
                mem_req       <= 1'b0;
                wb_valid      <= 1'b1;
                wb_register_d <= lat_rd;
                if (mem_we) begin
                    wb_write <= 1'b0;
                    wb_data  <= mem_addr;
                end else begin
                    wb_write <= lat_write;
                    wb_data  <= mem_rdata;
                end
            end else if (done_abort) begin
                mem_req       <= 1'b0;
                wb_valid      <= 1'b1;
                wb_write      <= 1'b0;
                wb_data       <= mem_addr;
                wb_register_d <= lat_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, is_write_in, is_load_in, is_store_in;
    logic [31:0] alu_result_in, store_data_in;
    logic [4:0]  register_d_in;
    logic        stall_out, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_write;
    logic [31:0] wb_data;
    logic [4:0]  wb_register_d;
    logic        mem_error;

    int n_pass  = 0;
    int n_total = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .valid_in(valid_in), .is_write_in(is_write_in),
        .is_load_in(is_load_in), .is_store_in(is_store_in),
        .alu_result_in(alu_result_in), .register_d_in(register_d_in),
        .store_data_in(store_data_in),
        .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_write(wb_write), .wb_data(wb_data),
        .wb_register_d(wb_register_d), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w, ld, st;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] sd;
        int          dly;
        logic [31:0] rdata;
        logic        e_we, e_write;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Issue one instruction at a negedge and follow it through to its
    // writeback beat; leaves the bench at the negedge after the wb edge.
    task automatic run_op(input string nm, input vec_t v);
        int n;
        valid_in = 1'b1; is_write_in = v.w; is_load_in = v.ld; is_store_in = v.st;
        alu_result_in = v.alu; register_d_in = v.rd; store_data_in = v.sd;
        mem_ready = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        if (v.ld || v.st) begin
            n = 0;
            while (mem_req && n < 64) begin
                chk({nm, " stall"}, stall_out, 1'b1);
                chk({nm, " addr"}, mem_addr, v.alu);
                chk({nm, " we"}, mem_we, v.e_we);
                if (v.e_we) chk({nm, " wdata"}, mem_wdata, v.sd);
                mem_ready = (n == v.dly);
                mem_rdata = (n == v.dly) ? v.rdata : $urandom;
                n++;
                @(negedge clk);
            end
            mem_ready = 1'b0;
            chk({nm, " req_cycles"}, n, v.dly + 1);
        end
        chk({nm, " wb_valid"}, wb_valid, 1'b1);
        chk({nm, " wb_write"}, wb_write, v.e_write);
        chk({nm, " wb_data"}, wb_data, v.e_data);
        chk({nm, " wb_rd"}, wb_register_d, v.e_rd);
        chk({nm, " stall_after"}, stall_out, 1'b0);
        chk({nm, " req_after"}, mem_req, 1'b0);
        chk({nm, " err"}, mem_error, 1'b0);
    endtask

    task automatic idle_cycle(input logic [31:0] held_data);
        valid_in = 1'b0;
        mem_ready = 1'b1;  // stray ready while IDLE must do nothing
        @(negedge clk);
        mem_ready = 1'b0;
        chk("idle wb_valid", wb_valid, 1'b0);
        chk("idle wb_write", wb_write, 1'b0);
        chk("idle wb_data_hold", wb_data, held_data);
        chk("idle req", mem_req, 1'b0);
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, " stall"}, stall_out, 1'b0);
        chk({nm, " req"}, mem_req, 1'b0);
        chk({nm, " we"}, mem_we, 1'b0);
        chk({nm, " addr"}, mem_addr, 32'h0);
        chk({nm, " wdata"}, mem_wdata, 32'h0);
        chk({nm, " wb_valid"}, wb_valid, 1'b0);
        chk({nm, " wb_write"}, wb_write, 1'b0);
        chk({nm, " wb_data"}, wb_data, 32'h0);
        chk({nm, " wb_rd"}, wb_register_d, 5'h0);
        chk({nm, " err"}, mem_error, 1'b0);
    endtask

    vec_t vt[6];
    vec_t rv;

    initial begin
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_1234, 5'd5,  32'h0,         0, 32'h0,         1'b0, 1'b1, 32'h0000_1234, 5'd5};
        vt[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 5'd7,  32'h0,         3, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 5'd7};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 5'd2,  32'hA5A5_A5A5, 0, 32'h0,         1'b1, 1'b0, 32'h0000_0200, 5'd2};
        vt[3] = '{1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 5'd31, 32'h0,         0, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 5'd31};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h0000_0044, 5'd9,  32'h1111_2222, 1, 32'h7777_7777, 1'b1, 1'b0, 32'h0000_0044, 5'd9};
        vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0080, 5'd1,  32'h0,         0, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_0055, 5'd1};

        reset = 1'b1; valid_in = 1'b0; is_write_in = 1'b0; is_load_in = 1'b0;
        is_store_in = 1'b0; alu_result_in = '0; register_d_in = '0;
        store_data_in = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");

        // Reset while a load is outstanding abandons it.
        reset = 1'b0;
        valid_in = 1'b1; is_load_in = 1'b1; is_write_in = 1'b1;
        alu_result_in = 32'h500; register_d_in = 5'd4;
        @(negedge clk);
        valid_in = 1'b0; is_load_in = 1'b0;
        chk("rst_pre req", mem_req, 1'b1);
        chk("rst_pre stall", stall_out, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("rst_access");
        reset = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rst_post wb_valid", wb_valid, 1'b0);
        chk("rst_post req", mem_req, 1'b0);
        @(negedge clk);
        chk("rst_post2 wb_valid", wb_valid, 1'b0);
        mem_ready = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vt[i]);
            idle_cycle(vt[i].e_data);
        end

        // Back-to-back: load, then an ALU op held by the bench under stall.
        valid_in = 1'b1; is_load_in = 1'b1; is_store_in = 1'b0; is_write_in = 1'b1;
        alu_result_in = 32'h120; register_d_in = 5'd6;
        @(negedge clk);
        chk("b2b req", mem_req, 1'b1);
        is_load_in = 1'b0; alu_result_in = 32'h77; register_d_in = 5'd8;
        @(negedge clk);
        chk("b2b held wb_valid", wb_valid, 1'b0);
        chk("b2b stall", stall_out, 1'b1);
        mem_ready = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("b2b ld wb_valid", wb_valid, 1'b1);
        chk("b2b ld wb_data", wb_data, 32'h99);
        chk("b2b ld wb_rd", wb_register_d, 5'd6);
        chk("b2b stall_rel", stall_out, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        chk("b2b alu wb_valid", wb_valid, 1'b1);
        chk("b2b alu wb_data", wb_data, 32'h77);
        chk("b2b alu wb_rd", wb_register_d, 5'd8);
        chk("b2b alu wb_write", wb_write, 1'b1);
        @(negedge clk);
        chk("b2b end wb_valid", wb_valid, 1'b0);

        // Random instructions against a plain behavioural expectation.
        for (int i = 0; i < 40; i++) begin
            rv.w = 1'($urandom); rv.alu = $urandom; rv.rd = 5'($urandom);
            rv.sd = $urandom; rv.rdata = $urandom; rv.dly = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: begin rv.ld = 1'b1; rv.st = 1'b0; end
                1: begin rv.ld = 1'b0; rv.st = 1'b1; end
                2: begin rv.ld = 1'b1; rv.st = 1'b1; end
                default: begin rv.ld = 1'b0; rv.st = 1'b0; end
            endcase
            rv.e_we    = rv.st;
            rv.e_write = rv.st ? 1'b0 : rv.w;
            rv.e_data  = rv.st ? rv.alu : (rv.ld ? rv.rdata : rv.alu);
            rv.e_rd    = rv.rd;
            run_op($sformatf("rnd%0d", i), rv);
            if ($urandom_range(0, 1) == 1) idle_cycle(rv.e_data);
        end

`ifdef MEM_TIMEOUT_EN
        begin
            int n;
            valid_in = 1'b1; is_load_in = 1'b1; is_store_in = 1'b0; is_write_in = 1'b1;
            alu_result_in = 32'h300; register_d_in = 5'd3; mem_ready = 1'b0;
            @(negedge clk);
            valid_in = 1'b0;
            n = 0;
            while (mem_req && n < 20) begin
                n++;
                @(negedge clk);
            end
            chk("to req_cycles", n, 4);
            chk("to err", mem_error, 1'b1);
            chk("to wb_valid", wb_valid, 1'b1);
            chk("to wb_write", wb_write, 1'b0);
            chk("to stall", stall_out, 1'b0);
            @(negedge clk);
            chk("to err_pulse", mem_error, 1'b0);
            rv = '{1'b1, 1'b1, 1'b0, 32'h0000_0340, 5'd12, 32'h0, 3, 32'h0BAD_CAFE,
                   1'b0, 1'b1, 32'h0BAD_CAFE, 5'd12};
            run_op("to_ready_on_expiry", rv);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
